// File: rtl/median_line_ram.sv
// Two-port line-buffer RAM for the median-filter SRAM controller, with a zero-fill engine and range checking.
// Optional feature: define MEDIAN_RAM_RD_BYPASS_EN for write-first same-address reads (default read-first).
module median_line_ram #(
    parameter int WIDTH = 9,
    parameter int LANES = 10,
    parameter int DEPTH = 2048
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic [10:0]              width,
    input  logic                     wr_en,
    input  logic [10:0]              wr_addr,
    input  logic [WIDTH*LANES-1:0]   D,
    input  logic [WIDTH*LANES-1:0]   BWEB,
    input  logic                     rd_en,
    input  logic [10:0]              rd_addr,
    output logic [WIDTH*LANES-1:0]   Q,
    output logic                     init_busy,
    output logic                     addr_err
);

    localparam int              DW      = WIDTH * LANES;
    localparam logic [11:0]     DEPTH_W = 12'(DEPTH);
    localparam logic [10:0]     LAST    = 11'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [10:0]     cnt_q, cnt_d;
    logic [DW-1:0]   q_q, q_d;
    logic            err_q, err_d;

    logic [DW-1:0]   mem [DEPTH];

    logic [11:0]     lim_s;
    logic            wr_in_s;
    logic            rd_in_s;
    logic [DW-1:0]   merged_s;
    logic [DW-1:0]   rd_word_s;
    logic            mem_we_s;
    logic [10:0]     mem_addr_s;
    logic [DW-1:0]   mem_wdata_s;

    // Effective line width (0 or oversize means the full depth) and the per-port range checks.
    always_comb begin
        if ((width == 11'd0) || ({1'b0, width} > DEPTH_W)) begin
            lim_s = DEPTH_W;
        end else begin
            lim_s = {1'b0, width};
        end
        wr_in_s  = ({1'b0, wr_addr} < lim_s);
        rd_in_s  = ({1'b0, rd_addr} < lim_s);
        merged_s = (mem[wr_addr] & BWEB) | (D & ~BWEB);
`ifdef MEDIAN_RAM_RD_BYPASS_EN
        if (wr_en && wr_in_s && (wr_addr == rd_addr)) begin
            rd_word_s = merged_s;
        end else begin
            rd_word_s = mem[rd_addr];
        end
`else
        rd_word_s = mem[rd_addr];
`endif
    end

    // Next-state, clear engine and access control.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        q_d         = q_q;
        err_d       = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = wr_addr;
        mem_wdata_s = merged_s;
        case (state_q)
            ST_CLEAR: begin
                mem_we_s    = 1'b1;
                mem_addr_s  = cnt_q;
                mem_wdata_s = {DW{1'b0}};
                q_d         = {DW{1'b0}};
                if (cnt_q == LAST) begin
                    state_d = ST_READY;
                    cnt_d   = 11'd0;
                end else begin
                    state_d = ST_CLEAR;
                    cnt_d   = cnt_q + 11'd1;
                end
            end
            ST_READY: begin
                mem_we_s = wr_en && wr_in_s;
                if (rd_en) begin
                    q_d = rd_in_s ? rd_word_s : {DW{1'b0}};
                end else begin
                    q_d = q_q;
                end
                // Both ports out of range in one cycle still yield a single pulse.
                err_d = (wr_en && !wr_in_s) || (rd_en && !rd_in_s);
                if (clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = 11'd0;
                end else begin
                    state_d = ST_READY;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = 11'd0;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= 11'd0;
            q_q     <= {DW{1'b0}};
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            err_q   <= err_d;
        end
    end

    // Storage array; contents are not reset, the clear engine zero-fills them.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[mem_addr_s] <= mem_wdata_s;
        end
    end

    assign Q         = q_q;
    assign addr_err  = err_q;
    assign init_busy = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_median_line_ram.sv
// Self-checking bench for median_line_ram: directed scenarios plus randomized READY traffic
// checked against an array-based reference model.
module tb_median_line_ram;

    localparam int DW    = 90;
    localparam int DEPTH = 2048;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic [10:0]   width;
    logic          wr_en;
    logic [10:0]   wr_addr;
    logic [DW-1:0] d;
    logic [DW-1:0] bweb;
    logic          rd_en;
    logic [10:0]   rd_addr;
    logic [DW-1:0] q;
    logic          init_busy;
    logic          addr_err;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mem_m [DEPTH];
    logic [DW-1:0] q_m;

    median_line_ram dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .width     (width),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .D         (d),
        .BWEB      (bweb),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .Q         (q),
        .init_busy (init_busy),
        .addr_err  (addr_err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rnd90();
        logic [DW-1:0] r;
        r[31:0]  = $urandom();
        r[63:32] = $urandom();
        r[89:64] = 26'($urandom());
        return r;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        clr   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        d     = {DW{1'b0}};
        bweb  = {DW{1'b1}};
    endtask

    task automatic noise();
        wr_en   = 1'($urandom());
        rd_en   = 1'($urandom());
        wr_addr = 11'($urandom());
        rd_addr = 11'($urandom());
        d       = rnd90();
        bweb    = {DW{1'b0}};
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = {DW{1'b0}};
        q_m = {DW{1'b0}};
    endtask

    // One READY cycle: predict from the rules, clock, then compare.
    task automatic tick(input string tag);
        int            eff;
        logic          wr_ok, rd_ok, exp_err;
        logic [DW-1:0] nw;
        eff     = (width == 11'd0) ? DEPTH : int'(width);
        wr_ok   = wr_en && (int'(wr_addr) < eff);
        rd_ok   = rd_en && (int'(rd_addr) < eff);
        exp_err = (wr_en && !wr_ok) || (rd_en && !rd_ok);
        nw      = (mem_m[wr_addr] & bweb) | (d & ~bweb);
        if (rd_en) begin
            if (!rd_ok) q_m = {DW{1'b0}};
`ifdef MEDIAN_RAM_RD_BYPASS_EN
            else if (wr_ok && (wr_addr == rd_addr)) q_m = nw;
`endif
            else q_m = mem_m[rd_addr];
        end
        if (wr_ok) mem_m[wr_addr] = nw;
        @(posedge clk); #1;
        chk({tag, "_q"}, q, q_m);
        chk({tag, "_err"}, {89'd0, addr_err}, {89'd0, exp_err});
        chk({tag, "_busy"}, {89'd0, init_busy}, {89'd0, clr});
    endtask

    // Count cycles until init_busy drops; optionally hammer the ports meanwhile.
    task automatic fill_wait(input string tag, input bit noisy, input int already);
        int n;
        n = already;
        while (init_busy === 1'b1 && n < 3000) begin
            if (noisy) noise();
            @(posedge clk); #1;
            n++;
            if (noisy) begin
                chk({tag, "_q0"}, q, {DW{1'b0}});
                chk({tag, "_err0"}, {89'd0, addr_err}, 90'd0);
            end
        end
        chk({tag, "_len"}, DW'(n), DW'(DEPTH));
        idle();
        model_clear();
    endtask

    initial begin
        rst = 1'b1; width = 11'd640; wr_addr = 11'd0; rd_addr = 11'd0;
        idle();
        @(posedge clk); #1;
        chk("rst_q", q, {DW{1'b0}});
        chk("rst_err", {89'd0, addr_err}, 90'd0);
        chk("rst_busy", {89'd0, init_busy}, 90'd1);
        rst = 1'b0;
        fill_wait("fill0", 1'b0, 0);

        for (int i = 0; i < 4; i++) begin
            rd_en = 1'b1; rd_addr = 11'($urandom_range(0, 639));
            tick("read_zero");
        end
        idle();

        // Full write then read-back, Q holds with rd_en low.
        width = 11'd640;
        wr_en = 1'b1; wr_addr = 11'd5; d = {10{9'h1A5}}; bweb = {DW{1'b0}};
        tick("wr5");
        wr_addr = 11'd7;
        tick("wr7");
        idle(); rd_en = 1'b1; rd_addr = 11'd5;
        tick("rd5");
        chk("rd5_abs", q, {10{9'h1A5}});
        idle();
        tick("hold1");
        rd_addr = 11'd6;
        tick("hold2");
        chk("hold_abs", q, {10{9'h1A5}});

        // Partial write of lane 9 only.
        wr_en = 1'b1; wr_addr = 11'd7; bweb = {9'h000, {9{9'h1FF}}}; d = {9'h0FF, 81'(rnd90())};
        tick("part_wr");
        idle(); rd_en = 1'b1; rd_addr = 11'd7;
        tick("part_rd");
        chk("part_abs", q, {9'h0FF, {9{9'h1A5}}});

        // Both ports out of range in one cycle.
        idle(); wr_en = 1'b1; rd_en = 1'b1; wr_addr = 11'd640; rd_addr = 11'd700;
        d = {10{9'h155}}; bweb = {DW{1'b0}};
        tick("oor");
        chk("oor_abs", {89'd0, addr_err}, 90'd1);
        idle();
        tick("oor_after");
        width = 11'd0; rd_en = 1'b1; rd_addr = 11'd640;
        tick("oor_mem");
        chk("oor_mem_abs", q, {DW{1'b0}});

        // Same-cycle write and read of one address.
        idle(); width = 11'd640;
        wr_en = 1'b1; wr_addr = 11'd3; d = {10{9'h011}}; bweb = {DW{1'b0}};
        tick("wr3");
        d = {10{9'h022}}; rd_en = 1'b1; rd_addr = 11'd3;
        tick("same");
`ifdef MEDIAN_RAM_RD_BYPASS_EN
        chk("same_abs", q, {10{9'h022}});
`else
        chk("same_abs", q, {10{9'h011}});
`endif

        // Randomized READY traffic.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 4))
                0: width = 11'd0;
                1: width = 11'd8;
                2: width = 11'd12;
                3: width = 11'd640;
                default: width = 11'd2047;
            endcase
            wr_en   = 1'($urandom());
            rd_en   = 1'($urandom());
            wr_addr = ($urandom_range(0, 7) == 0) ? 11'($urandom()) : 11'($urandom_range(0, 15));
            rd_addr = ($urandom_range(0, 7) == 0) ? 11'($urandom()) : 11'($urandom_range(0, 15));
            d       = rnd90();
            case ($urandom_range(0, 3))
                0: bweb = {DW{1'b1}};
                1: bweb = {DW{1'b0}};
                default: bweb = rnd90();
            endcase
            tick("rand");
        end

        // clr with a concurrent write, then rst mid-clear, then full refill.
        idle(); width = 11'd640;
        clr = 1'b1; wr_en = 1'b1; wr_addr = 11'd9; d = {10{9'h0AA}}; bweb = {DW{1'b0}};
        tick("clr");
        for (int i = 1; i < 100; i++) begin
            noise();
            @(posedge clk); #1;
            chk("clr_q0", q, {DW{1'b0}});
            chk("clr_busy", {89'd0, init_busy}, 90'd1);
        end
        idle(); rst = 1'b1;
        @(posedge clk); #1;
        chk("rst2_busy", {89'd0, init_busy}, 90'd1);
        rst = 1'b0;
        fill_wait("fill2", 1'b1, 0);
        width = 11'd0;
        rd_en = 1'b1; rd_addr = 11'd9;
        tick("post9");
        rd_addr = 11'd7;
        tick("post7");
        for (int i = 0; i < 6; i++) begin
            rd_addr = 11'($urandom());
            tick("post_rand");
        end
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
